seq_mult8: RTL and testbench

- Sequential unsigned shift-add multiplier: WIDTH x WIDTH operands -> 2*WIDTH product, one add/shift step per clock.
- Sits directly upstream of the datapath adder stage. Each step generates one WIDTH-bit addition of the partial-product high half and the multiplicand, and consumes the sum and carry-out.
- Serves the ALU multiply path. A start/busy/done handshake replaces a large combinational array.

---
 rtl/seq_mult8.sv | 154 +++++++++++++++
 tb/tb_seq_mult8.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult8.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult8
//  Purpose  : Sequential unsigned shift-add multiplier. One WIDTH-bit add and
//             one right shift per clock; WIDTH steps produce a 2*WIDTH-bit
//             product. A start/busy/done handshake replaces a combinational
//             multiplier array.
//  Ports    : clk     - rising-edge clock
//             rst     - synchronous reset, active-high
//             start   - request a multiply (accepted in IDLE or DONE)
//             a       - multiplicand, captured on accept
//             b       - multiplier, captured on accept
//             busy    - high while the multiply is stepping (RUN)
//             done    - one-cycle pulse, product valid in the same cycle
//             product - result, held until the next completion or reset
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mult8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0]    c_ST_IDLE  = 2'd0;
    localparam logic [1:0]    c_ST_RUN   = 2'd1;
    localparam logic [1:0]    c_ST_DONE  = 2'd2;
    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [WIDTH-1:0]    r_acc_hi;
    logic [WIDTH-1:0]    r_mq;
    logic [WIDTH-1:0]    r_mcand;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [2*WIDTH-1:0]  r_product;

    logic                w_accept;
    logic                w_last_step;
    logic [WIDTH:0]      w_addend;
    logic [WIDTH:0]      w_sum;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    // A new operation may begin from IDLE or directly from DONE, which lets
    // back-to-back requests run without a bubble cycle.
    assign w_accept    = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_last_step = (r_state == c_ST_RUN) && (r_cnt == c_CNT_LAST);

    // Full-width sum: bit WIDTH is the carry, which is shifted into the top
    // of acc_hi so no partial-product bit is ever lost.
    assign w_addend = r_mq[0] ? {1'b0, r_mcand} : '0;
    assign w_sum    = {1'b0, r_acc_hi} + w_addend;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_last_step) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = w_accept ? c_ST_RUN : c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Decoded from the next state so the status flags can be registered and
    // still line up with the state they describe.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            c_ST_RUN:  w_busy_nxt = 1'b1;
            c_ST_DONE: w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------- datapath
    // Operands are loaded only on accept, so a/b are don't-care otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_hi  <= '0;
            r_mq      <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_acc_hi <= '0;
            r_mq     <= b;
            r_mcand  <= a;
            r_cnt    <= '0;
        end else if (r_state == c_ST_RUN) begin
            // {acc_hi, mq} <= {carry, sum, mq} >> 1
            r_acc_hi <= w_sum[WIDTH:1];
            r_mq     <= {w_sum[0], r_mq[WIDTH-1:1]};
            r_cnt    <= r_cnt + c_CNT_ONE;
            if (w_last_step) begin
                r_product <= {w_sum, r_mq[WIDTH-1:1]};
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mult8
//  Purpose  : Self-checking bench for seq_mult8. Expected products come from
//             plain multiplication; expected timing from the handshake rules
//             (busy for WIDTH cycles after accept, done in the next cycle).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult8;

    localparam int W   = 8;
    localparam int LAT = W + 1;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_checks;
    int n_pass;

    seq_mult8 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned p;
        p = int'(x) * int'(y);
        return p[2*W-1:0];
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high for one edge, then drop start and
    // drive X on the operands.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        a     = 'x;
        b     = 'x;
    endtask

    // Called in the first cycle after an accept. Returns the cycle index
    // (1 = first cycle after accept) where done is seen, or 0 on timeout,
    // and the number of busy cycles before it. Leaves time in the done cycle.
    task automatic wait_done(output int lat, output int nbusy, output logic [2*W-1:0] p);
        lat   = 0;
        nbusy = 0;
        p     = '0;
        for (int k = 1; k <= 40; k++) begin
            if (done === 1'b1) begin
                lat = k;
                p   = product;
                break;
            end
            if (busy === 1'b1) nbusy++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd9;
        tick();
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0)
            $display("FAIL reset_state: busy=%b done=%b product=%h, required 0 0 0000", busy, done, product);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat, nb;
        logic [2*W-1:0] p;
        start_op(8'd13, 8'd11);
        wait_done(lat, nb, p);
        n_checks++;
        if (lat !== LAT) $display("FAIL basic_latency: got %0d, required %0d", lat, LAT);
        else n_pass++;
        n_checks++;
        if (nb !== W) $display("FAIL basic_busy_cycles: got %0d, required %0d", nb, W);
        else n_pass++;
        n_checks++;
        if (p !== 16'h008F) $display("FAIL basic_product: got %h, required 008f", p);
        else n_pass++;
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if (product !== 16'h008F || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_hold: product=%h done=%b busy=%b, required 008f 0 0", product, done, busy);
        else n_pass++;
    endtask

    task automatic test_boundaries();
        int lat, nb;
        logic [2*W-1:0] p;
        start_op(8'd255, 8'd255);
        wait_done(lat, nb, p);
        n_checks++;
        if (p !== 16'hFE01 || lat !== LAT)
            $display("FAIL max_operands: product=%h lat=%0d, required fe01 %0d", p, lat, LAT);
        else n_pass++;
        tick();
        start_op(8'd0, 8'd200);
        wait_done(lat, nb, p);
        n_checks++;
        if (p !== 16'h0000 || lat !== LAT)
            $display("FAIL zero_operand: product=%h lat=%0d, required 0000 %0d", p, lat, LAT);
        else n_pass++;
        tick();
    endtask

    task automatic test_start_ignored();
        int ndone;
        logic [2*W-1:0] p;
        ndone = 0;
        p     = '0;
        start_op(8'd3, 8'd5);
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) begin
                start = 1'b1; a = 8'd7; b = 8'd7;
            end else begin
                start = 1'b0; a = 'x; b = 'x;
            end
            if (done === 1'b1) begin
                ndone++;
                p = product;
            end
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (ndone !== 1) $display("FAIL ignore_start_done_count: got %0d, required 1", ndone);
        else n_pass++;
        n_checks++;
        if (p !== 16'h000F) $display("FAIL ignore_start_product: got %h, required 000f", p);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        logic [2*W-1:0] p;
        start = 1'b1; a = 8'd16; b = 8'd16;
        tick();
        wait_done(lat, nb, p);
        n_checks++;
        if (p !== 16'h0100 || lat !== LAT || nb !== W)
            $display("FAIL b2b_first: product=%h lat=%0d busy=%0d, required 0100 %0d %0d", p, lat, nb, LAT, W);
        else n_pass++;
        a = 8'd1; b = 8'd128;
        tick();
        wait_done(lat, nb, p);
        start = 1'b0;
        n_checks++;
        if (p !== 16'h0080 || lat !== LAT || nb !== W)
            $display("FAIL b2b_second: product=%h lat=%0d busy=%0d, required 0080 %0d %0d", p, lat, nb, LAT, W);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat, nb, ndone;
        logic [2*W-1:0] p;
        ndone = 0;
        start_op(8'd200, 8'd3);
        for (int k = 1; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0)
            $display("FAIL reset_mid_run: busy=%b done=%b product=%h, required 0 0 0000", busy, done, product);
        else n_pass++;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        n_checks++;
        if (ndone !== 0) $display("FAIL reset_abort_no_done: got %0d done pulses, required 0", ndone);
        else n_pass++;
        start_op(8'd2, 8'd2);
        wait_done(lat, nb, p);
        n_checks++;
        if (p !== 16'h0004 || lat !== LAT)
            $display("FAIL after_reset_op: product=%h lat=%0d, required 0004 %0d", p, lat, LAT);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int lat, nb, gap;
        logic [W-1:0] ra, rb;
        logic [2*W-1:0] p, exp_p;
        for (int i = 0; i < 1000; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                start = 1'b0; a = 'x; b = 'x;
                tick();
            end
            exp_p = ref_mul(ra, rb);
            start_op(ra, rb);
            wait_done(lat, nb, p);
            n_checks++;
            if (p !== exp_p)
                $display("FAIL random_product[%0d]: %0d*%0d got %h, required %h", i, ra, rb, p, exp_p);
            else n_pass++;
            n_checks++;
            if (lat !== LAT || nb !== W)
                $display("FAIL random_timing[%0d]: lat=%0d busy=%0d, required %0d %0d", i, lat, nb, LAT, W);
            else n_pass++;
        end
        start = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        #1;
        test_reset();
        test_basic();
        test_boundaries();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
